// File: rtl/kbd_scan_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, matrix geometry,
// and the active-low column decode used by the scanner and anything reusing it.
package kbd_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam int KEY_W   = 4;
  localparam int ROWS    = 4;
  localparam int COLS    = 4;
  localparam int ENTRY_W = 24;

  // Index of the single low column; multi-low patterns never reach this.
  function automatic logic [1:0] enc(input logic [COLS-1:0] pat);
    case (pat)
      4'b1110: enc = 2'd0;
      4'b1101: enc = 2'd1;
      4'b1011: enc = 2'd2;
      4'b0111: enc = 2'd3;
      default: enc = 2'd0;
    endcase
  endfunction

  function automatic logic single(input logic [COLS-1:0] pat);
    single = (pat == 4'b1110) || (pat == 4'b1101) ||
             (pat == 4'b1011) || (pat == 4'b0111);
  endfunction
endpackage

// File: rtl/kbd_scan_if.sv
// Keypad-side and consumer-side signals of the scanner; master is the scanner.
interface kbd_scan_if;
  import kbd_pkg::*;
  logic [COLS-1:0]    col_in;
  logic [ROWS-1:0]    row_out;
  logic [KEY_W-1:0]   key_code;
  logic               key_valid;
  logic               key_held;
  logic [ENTRY_W-1:0] entry;

  modport master (input col_in, output row_out, key_code, key_valid, key_held, entry);
  modport slave  (output col_in, input row_out, key_code, key_valid, key_held, entry);
endinterface

// File: rtl/kbd_scan_ms_tick.sv
// Free-running prescaler: one-clk tick every T1MS cycles, shared with the
// display refresh logic.
module ms_tick #(
  parameter int T1MS = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = (T1MS > 1) ? $clog2(T1MS) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(T1MS - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + W'(1);
endmodule

// File: rtl/kbd_scan.sv
// 4x4 keypad scanner: row-at-a-time drive, tick-paced debounce of press and
// release, key code strobe and a six-digit entry shift register.
module kbd_scan
  import kbd_pkg::*;
#(
  parameter int T1MS        = 50_000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic     clk,
  input  logic     rst_n,
  kbd_scan_if.master bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

  state_t             state, state_nx;
  logic [COLS-1:0]    col_m, col_s, col_pat, pat_nx;
  logic [1:0]         row_idx, row_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               tick, accept, key_held, key_valid;
  logic [KEY_W-1:0]   key_code, new_code;
  logic [ENTRY_W-1:0] entry;

  ms_tick #(.T1MS(T1MS)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  assign new_code     = {row_idx, enc(col_pat)};
  assign bus.row_out  = ~(ROWS'(1) << row_idx);
  assign bus.key_code = key_code;
  assign bus.key_valid = key_valid;
  assign bus.key_held = key_held;
  assign bus.entry    = entry;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= SCAN;
    else        state <= state_nx;

  // Everything holds between ticks; the counter completes one tick early so
  // the DEBOUNCE_MS-th matching tick is the one that commits.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    row_nx   = row_idx;
    pat_nx   = col_pat;
    accept   = 1'b0;
    if (tick) begin
      case (state)
        SCAN:
          if (single(col_s)) begin
            state_nx = DEBOUNCE;
            pat_nx   = col_s;
            cnt_nx   = '0;
          end else begin
            row_nx = row_idx + 2'd1;
          end
        DEBOUNCE:
          if (col_s == col_pat) begin
            if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
              state_nx = HELD;
              cnt_nx   = '0;
              accept   = 1'b1;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end else begin
            state_nx = SCAN;
            row_nx   = row_idx + 2'd1;
          end
        HELD:
          if (col_s == '1) begin
            if (cnt == CNT_W'(DEBOUNCE_MS - 1)) begin
              state_nx = SCAN;
              cnt_nx   = '0;
              row_nx   = row_idx + 2'd1;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end else begin
            cnt_nx = '0;
          end
        default: state_nx = SCAN;
      endcase
    end
  end

  always_comb begin
    key_held = (state == HELD);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_m     <= '1;
      col_s     <= '1;
      col_pat   <= '1;
      row_idx   <= '0;
      cnt       <= '0;
      key_valid <= 1'b0;
      key_code  <= '0;
      entry     <= '0;
    end else begin
      col_m     <= bus.col_in;
      col_s     <= col_m;
      col_pat   <= pat_nx;
      row_idx   <= row_nx;
      cnt       <= cnt_nx;
      key_valid <= accept;
      if (accept) begin
        key_code <= new_code;
        entry    <= {entry[ENTRY_W-KEY_W-1:0], new_code};
      end
    end
endmodule
